// File: rtl/render_sequencer.sv
// render_sequencer
//
// Walks every pixel of a frame in raster order and, for each pixel, steps a
// collision-detection unit through all spheres, keeping the closest hit. Once
// every sphere has been tested the pixel is emitted with a one-cycle Write
// strobe.
//
// Per-pixel flow: wait for the ray LUT to settle, test each sphere, then write.
//
// Ports
//   Clk         single clock, rising edge
//   Reset       synchronous, active-high
//   Start       begin a frame (honoured only while idle)
//   Continuous  restart at (0,0) after the last pixel without a new Start
//   CdValid     collision result valid for the current SphereIdx
//   Collide     ray hits sphere SphereIdx (qualified by CdValid)
//   TNew        hit distance, unsigned 16.16 (qualified by CdValid & Collide)
//   WriteX/Y    current pixel column / row
//   SphereIdx   sphere under test
//   TBest       closest accepted hit so far for the current pixel
//   HitAny      current pixel has at least one accepted hit
//   HitIdx      index of the closest sphere hit
//   Write       frame-buffer write strobe for (WriteX, WriteY)
//   Busy        high whenever not idle
//   FrameDone   pulses together with the write of the last pixel
module render_sequencer #(
    parameter int unsigned NUM_SPHERES = 4,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned LUT_LATENCY = 2,
    parameter logic [31:0] T_MAX       = 32'h8FFF0000
) (
    input  logic                                                     Clk,
    input  logic                                                     Reset,
    input  logic                                                     Start,
    input  logic                                                     Continuous,
    input  logic                                                     CdValid,
    input  logic                                                     Collide,
    input  logic [31:0]                                              TNew,
    output logic [9:0]                                               WriteX,
    output logic [9:0]                                               WriteY,
    output logic [$clog2(NUM_SPHERES > 1 ? NUM_SPHERES : 2)-1:0]     SphereIdx,
    output logic [31:0]                                              TBest,
    output logic                                                     HitAny,
    output logic [$clog2(NUM_SPHERES > 1 ? NUM_SPHERES : 2)-1:0]     HitIdx,
    output logic                                                     Write,
    output logic                                                     Busy,
    output logic                                                     FrameDone
);

    localparam int unsigned IdxW = $clog2(NUM_SPHERES > 1 ? NUM_SPHERES : 2);
    localparam int unsigned LatW = $clog2(LUT_LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRayWait,
        StTest,
        StWrite
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       tbest_q, tbest_d;
    logic              hit_any_q, hit_any_d;
    logic [IdxW-1:0]   hit_idx_q, hit_idx_d;
    logic [LatW-1:0]   lat_q, lat_d;

    logic              last_col;
    logic              last_px;

    assign last_col = (x_q == 10'(H_RES - 1));
    assign last_px  = last_col && (y_q == 10'(V_RES - 1));

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            tbest_q   <= T_MAX;
            hit_any_q <= 1'b0;
            hit_idx_q <= '0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            tbest_q   <= tbest_d;
            hit_any_q <= hit_any_d;
            hit_idx_q <= hit_idx_d;
            lat_q     <= lat_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        idx_d     = idx_q;
        tbest_d   = tbest_q;
        hit_any_d = hit_any_q;
        hit_idx_d = hit_idx_q;
        lat_d     = lat_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d   = StRayWait;
                    x_d       = '0;
                    y_d       = '0;
                    idx_d     = '0;
                    tbest_d   = T_MAX;
                    hit_any_d = 1'b0;
                    hit_idx_d = '0;
                    lat_d     = '0;
                end
            end

            StRayWait: begin
                if (lat_q == LatW'(LUT_LATENCY - 1)) begin
                    state_d = StTest;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            StTest: begin
                if (CdValid) begin
                    // Strict compare: on a tie the earlier (lower) index is kept.
                    if (Collide && (TNew < tbest_q)) begin
                        tbest_d   = TNew;
                        hit_idx_d = idx_q;
                        hit_any_d = 1'b1;
                    end
                    if (idx_q == IdxW'(NUM_SPHERES - 1)) begin
                        state_d = StWrite;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StWrite: begin
                idx_d     = '0;
                tbest_d   = T_MAX;
                hit_any_d = 1'b0;
                lat_d     = '0;
                if (last_px) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = Continuous ? StRayWait : StIdle;
                end else begin
                    state_d = StRayWait;
                    if (last_col) begin
                        x_d = '0;
                        y_d = y_q + 10'd1;
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        WriteX    = x_q;
        WriteY    = y_q;
        SphereIdx = idx_q;
        TBest     = tbest_q;
        HitAny    = hit_any_q;
        HitIdx    = hit_idx_q;
        Write     = (state_q == StWrite);
        FrameDone = (state_q == StWrite) && last_px;
        Busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer
//
// Directed bench for render_sequencer on a 4x2 frame with 4 spheres and a
// 2-cycle LUT latency. Expected pixel writes (position, hit data and the
// exact cycle they must appear on) are queued when a frame is started and
// compared whenever the DUT raises Write.
module tb_render_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned HR = 4;
    localparam int unsigned VR = 2;
    localparam int unsigned LL = 2;
    localparam logic [31:0] TM = 32'h8FFF0000;
    localparam int          PIX_CYC = LL + NS + 1;
    localparam int          FIRST_WR = LL + NS;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Continuous;
    logic        CdValid;
    logic        Collide;
    logic [31:0] TNew;
    logic [9:0]  WriteX;
    logic [9:0]  WriteY;
    logic [1:0]  SphereIdx;
    logic [31:0] TBest;
    logic        HitAny;
    logic [1:0]  HitIdx;
    logic        Write;
    logic        Busy;
    logic        FrameDone;

    render_sequencer #(
        .NUM_SPHERES (NS),
        .H_RES       (HR),
        .V_RES       (VR),
        .LUT_LATENCY (LL),
        .T_MAX       (TM)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Continuous (Continuous),
        .CdValid    (CdValid),
        .Collide    (Collide),
        .TNew       (TNew),
        .WriteX     (WriteX),
        .WriteY     (WriteY),
        .SphereIdx  (SphereIdx),
        .TBest      (TBest),
        .HitAny     (HitAny),
        .HitIdx     (HitIdx),
        .Write      (Write),
        .Busy       (Busy),
        .FrameDone  (FrameDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hit_any;
        logic [1:0]  hit_idx;
        logic [31:0] tbest;
        logic        fd;
        int          cyc;
    } item_t;

    item_t       sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          stall_lo = 0;
    int          stall_hi = -1;
    logic [31:0] tnew_tab [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_write();
        item_t it;
        if (sb.size() == 0) begin
            check("unexpected_write", {31'd0, Write}, 32'd0);
        end else begin
            it = sb.pop_front();
            check("wr_x", {22'd0, WriteX}, {22'd0, it.x});
            check("wr_y", {22'd0, WriteY}, {22'd0, it.y});
            check("wr_hit_any", {31'd0, HitAny}, {31'd0, it.hit_any});
            check("wr_hit_idx", {30'd0, HitIdx}, {30'd0, it.hit_idx});
            check("wr_tbest", TBest, it.tbest);
            check("wr_frame_done", {31'd0, FrameDone}, {31'd0, it.fd});
            check("wr_cycle", cyc, it.cyc);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then drive the
    // inputs that the next edge will see.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (FrameDone && !Write) check("frame_done_alone", {31'd0, FrameDone}, 32'd0);
        if (Write) check_write();
        TNew    = tnew_tab[SphereIdx];
        CdValid = !(((cyc + 1) >= stall_lo) && ((cyc + 1) <= stall_hi));
    endtask

    // k is the edge at which Start is sampled; delay shifts every write.
    task automatic push_frame(input int k, input int count, input logic ha, input logic [1:0] hi,
                              input logic [31:0] tb, input int delay);
        item_t it;
        int    pix;
        for (int i = 0; i < count; i++) begin
            pix        = i % (HR * VR);
            it.x       = 10'(pix % HR);
            it.y       = 10'(pix / HR);
            it.hit_any = ha;
            it.hit_idx = hi;
            it.tbest   = tb;
            it.fd      = (pix == HR * VR - 1);
            it.cyc     = k + FIRST_WR + delay + PIX_CYC * i;
            sb.push_back(it);
        end
    endtask

    task automatic run_until_size(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() <= target) break;
            step();
        end
        check("queue_drain", sb.size(), target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, {22'd0, WriteX}, 32'd0);
        check({tag, "_y"}, {22'd0, WriteY}, 32'd0);
        check({tag, "_idx"}, {30'd0, SphereIdx}, 32'd0);
        check({tag, "_tbest"}, TBest, TM);
        check({tag, "_hit_any"}, {31'd0, HitAny}, 32'd0);
        check({tag, "_hit_idx"}, {30'd0, HitIdx}, 32'd0);
        check({tag, "_write"}, {31'd0, Write}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, FrameDone}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 4; i++) tnew_tab[i] = 32'd0;
        Reset      = 1'b1;
        Start      = 1'b1;
        Continuous = 1'b0;
        CdValid    = 1'b1;
        Collide    = 1'b0;
        TNew       = 32'd0;

        // Reset with Start held high at the same time.
        step();
        step();
        check_reset_vals("reset");
        Reset = 1'b0;
        Start = 1'b0;
        step();
        check("idle_after_reset", {31'd0, Busy}, 32'd0);

        // Frame A: no collisions, with a stray Start pulse mid-frame.
        Start = 1'b1;
        k     = cyc + 1;
        push_frame(k, HR * VR, 1'b0, 2'd0, TM, 0);
        step();
        Start = 1'b0;
        check("busy_after_start", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        run_until_size(0, 200);
        step();
        check("a_idle_busy", {31'd0, Busy}, 32'd0);
        check("a_idle_x", {22'd0, WriteX}, 32'd0);
        check("a_idle_y", {22'd0, WriteY}, 32'd0);
        for (int i = 0; i < 10; i++) step();

        // Frame C: continuous mode, then reset in TEST at pixel (2,1) of frame 2.
        Continuous = 1'b1;
        Start      = 1'b1;
        k          = cyc + 1;
        push_frame(k, HR * VR + 6, 1'b0, 2'd0, TM, 0);
        step();
        Start = 1'b0;
        run_until_size(6, 200);
        for (int i = 0; i < 3; i++) step();
        check("cont_busy", {31'd0, Busy}, 32'd1);
        check("cont_no_write", {31'd0, Write}, 32'd0);
        run_until_size(0, 200);
        for (int i = 0; i < 20; i++) begin
            if (cyc >= k + 101) break;
            step();
        end
        check("pre_reset_x", {22'd0, WriteX}, 32'd2);
        check("pre_reset_y", {22'd0, WriteY}, 32'd1);
        check("pre_reset_busy", {31'd0, Busy}, 32'd1);
        check("pre_reset_write", {31'd0, Write}, 32'd0);
        Reset      = 1'b1;
        Continuous = 1'b0;
        step();
        check_reset_vals("mid_reset");
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("post_reset_idle", {31'd0, Busy}, 32'd0);

        // Frame B: collisions {5,3,3,9}, CdValid stalled 5 cycles at sphere 1.
        Collide     = 1'b1;
        tnew_tab[0] = 32'd5 << 16;
        tnew_tab[1] = 32'd3 << 16;
        tnew_tab[2] = 32'd3 << 16;
        tnew_tab[3] = 32'd9 << 16;
        Start       = 1'b1;
        k           = cyc + 1;
        stall_lo    = k + 4;
        stall_hi    = k + 8;
        push_frame(k, HR * VR, 1'b1, 2'd1, 32'h00030000, 5);
        step();
        Start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cyc >= k + 8) break;
            step();
        end
        check("stall_idx", {30'd0, SphereIdx}, 32'd1);
        check("stall_tbest", TBest, 32'h00050000);
        check("stall_busy", {31'd0, Busy}, 32'd1);
        check("stall_write", {31'd0, Write}, 32'd0);
        run_until_size(0, 200);
        step();
        check("b_idle_busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameter NUM_SPHERES, default 4, number of spheres tested per pixel (1..16).
REQ-002 Parameter H_RES, default 640, pixels per line.
REQ-003 Parameter V_RES, default 480, lines per frame.
REQ-004 Parameter LUT_LATENCY, default 2, cycles from WriteX/WriteY change until the ray LUT output is valid (>=1).
REQ-005 Parameter T_MAX, default 32'h8FFF0000, initial best-distance per pixel (unsigned 16.16 fixed).
REQ-006 Clk  in  1  single clock; all logic on rising edge.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 Start  in  1  begin frame render; sampled only in IDLE.
REQ-009 Continuous  in  1  when 1, restart at pixel (0,0) after frame end without Start.
REQ-010 CdValid  in  1  collision-detection result valid for current SphereIdx.
REQ-011 Collide  in  1  ray hits sphere SphereIdx; qualified by CdValid.
REQ-012 TNew  in  32  hit distance, unsigned 16.16; qualified by CdValid & Collide.
REQ-013 WriteX  out  10  current pixel column.
REQ-014 WriteY  out  10  current pixel row.
REQ-015 SphereIdx  out  $clog2(NUM_SPHERES) (min 1)  sphere under test.
REQ-016 TBest  out  32  closest hit so far for current pixel; feeds collision unit tbest.
REQ-017 HitAny  out  1  current pixel has at least one accepted hit.
REQ-018 HitIdx  out  $clog2(NUM_SPHERES) (min 1)  index of closest sphere hit.
REQ-019 Write  out  1  one-cycle frame-buffer write strobe for (WriteX, WriteY).
REQ-020 Busy  out  1  high in every state except IDLE.
REQ-021 FrameDone  out  1  one-cycle pulse with the write of the last pixel.

Function
REQ-022 FSM states: IDLE, RAY_WAIT, TEST, WRITE; registered state, encoding free.
REQ-023 IDLE: on Start=1 -> RAY_WAIT with WriteX=0, WriteY=0, SphereIdx=0, TBest=T_MAX, HitAny=0, HitIdx=0; Start in other states ignored.
REQ-024 RAY_WAIT lasts exactly LUT_LATENCY cycles (internal counter), then -> TEST.
REQ-025 TEST: holds SphereIdx until CdValid=1; CdValid in same cycle as entry is accepted.
REQ-026 On CdValid with Collide=1 and TNew < TBest (unsigned, strict), next cycle TBest=TNew, HitIdx=SphereIdx, HitAny=1; otherwise unchanged.
REQ-027 Ties (TNew == TBest) not accepted; lower index wins.
REQ-028 On CdValid with SphereIdx < NUM_SPHERES-1: SphereIdx increments, stay TEST; with SphereIdx == NUM_SPHERES-1: -> WRITE.
REQ-029 WRITE lasts one cycle: Write=1; WriteX, WriteY, HitAny, HitIdx show the final values for the pixel.
REQ-030 Leaving WRITE: WriteX increments; at WriteX == H_RES-1 it wraps to 0 and WriteY increments; SphereIdx=0, TBest=T_MAX, HitAny=0 reloaded; -> RAY_WAIT.
REQ-031 Last pixel (H_RES-1, V_RES-1): FrameDone=1 in the WRITE cycle; next WriteX=0, WriteY=0; -> RAY_WAIT if Continuous=1, else IDLE.
REQ-032 Continuous is sampled only in the last-pixel WRITE cycle.
REQ-033 With CdValid tied high, each pixel takes exactly LUT_LATENCY + NUM_SPHERES + 1 cycles.
REQ-034 Write and FrameDone are never high outside WRITE; at most one Write per pixel.
REQ-035 CdValid in IDLE, RAY_WAIT or WRITE is ignored.

Reset
REQ-036 Reset=1 at a clock edge forces IDLE from any state, including mid-pixel and during WRITE.
REQ-037 Reset values: WriteX=0, WriteY=0, SphereIdx=0, TBest=T_MAX, HitAny=0, HitIdx=0, Write=0, Busy=0, FrameDone=0.
REQ-038 Reset overrides a simultaneous Start; Start is honoured no earlier than the first cycle after Reset deasserts.

Verification
REQ-039 NUM_SPHERES=4, H_RES=4, V_RES=2, LUT_LATENCY=2, CdValid=1, Collide=0, Start pulse -> 8 Write pulses spaced 7 cycles apart, HitAny=0 on each, FrameDone only with 8th, then IDLE and Busy=0.
REQ-040 Same setup, Collide=1 with TNew={5,3,3,9}<<16 for idx 0..3 -> Write with HitAny=1, HitIdx=1, TBest=32'h00030000.
REQ-041 CdValid held low 5 cycles in TEST -> SphereIdx, TBest and state hold; Write delayed by exactly 5 cycles.
REQ-042 Continuous=1 -> after FrameDone, next Write is at (0,0) after 7 cycles with no Start; Busy stays 1.
REQ-043 Reset asserted during TEST at pixel (2,1) -> next cycle IDLE, all outputs at reset values; later Start renders from (0,0).
REQ-044 Start pulsed while Busy -> no effect on pixel sequence or Write count.
